// File: rtl/ttfir_mac.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks all taps, one tap per clock.
// Coefficients are written at run time; the result is rounded, shifted and saturated.
module ttfir_mac #(
    parameter int N_TAPS  = 7,
    parameter int BW_in   = 6,
    parameter int BW_coef = 6,
    parameter int BW_out  = 8,
    parameter int SHIFT   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BW_in-1:0]            x_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic [BW_coef-1:0]          coef_in,
    output logic [BW_out-1:0]           y_out,
    output logic                        out_valid
);

    localparam int AW    = $clog2(N_TAPS);
    localparam int PW    = BW_in + BW_coef;
    localparam int ACC_W = PW + AW;
    localparam int RW    = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t                    state;
    logic signed [BW_in-1:0]   xd [N_TAPS];
    logic signed [BW_coef-1:0] cf [N_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic        [AW-1:0]      k;

    logic signed [BW_in-1:0]   xk;
    logic signed [BW_coef-1:0] ck;
    logic signed [PW-1:0]      xe;
    logic signed [PW-1:0]      ce;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [RW-1:0]      rsum;
    logic signed [RW-1:0]      rnd;
    logic signed [BW_out-1:0]  ysat;

    // Tap select as a compare mux so a counter value past N_TAPS-1 never indexes outside the arrays.
    always_comb begin
        xk = '0;
        ck = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            if (k == AW'(i)) begin
                xk = xd[i];
                ck = cf[i];
            end
        end
    end

    always_comb begin
        xe      = {{BW_coef{xk[BW_in-1]}}, xk};
        ce      = {{BW_in{ck[BW_coef-1]}}, ck};
        prod    = xe * ce;
        acc_nxt = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end

    generate
        if (SHIFT > 0) begin : g_round
            always_comb begin
                rsum = {acc_nxt[ACC_W-1], acc_nxt} + (RW'(1) << (SHIFT - 1));
                rnd  = rsum >>> SHIFT;
            end
        end else begin : g_noround
            always_comb begin
                rsum = {acc_nxt[ACC_W-1], acc_nxt};
                rnd  = rsum;
            end
        end

        if (BW_out < RW) begin : g_sat
            // Out of range whenever the bits above the output sign bit disagree with the sign.
            always_comb begin
                if (!rnd[RW-1] && (|rnd[RW-2:BW_out-1]))
                    ysat = {1'b0, {(BW_out-1){1'b1}}};
                else if (rnd[RW-1] && !(&rnd[RW-2:BW_out-1]))
                    ysat = {1'b1, {(BW_out-1){1'b0}}};
                else
                    ysat = rnd[BW_out-1:0];
            end
        end else begin : g_wide
            always_comb ysat = BW_out'(rnd);
        end
    endgenerate

    always_comb in_ready = (state == IDLE);

    // y_out/out_valid are loaded on the edge entering DONE, so they are valid while DONE is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                xd[i] <= '0;
                cf[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Addresses at or above N_TAPS match no entry and are dropped.
                    if (coef_we) begin
                        for (int unsigned i = 0; i < N_TAPS; i++) begin
                            if (coef_addr == AW'(i))
                                cf[i] <= coef_in;
                        end
                    end
                    if (in_valid) begin
                        xd[0] <= x_in;
                        for (int unsigned i = 1; i < N_TAPS; i++)
                            xd[i] <= xd[i-1];
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + 1'b1;
                    if (k == AW'(N_TAPS - 1)) begin
                        y_out     <= ysat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ttfir_mac.md
# ttfir_mac

Time-multiplexed, coefficient-programmable FIR filter. It is the parametrised successor of the fixed-coefficient 7-tap FIR in the TinyTapeout tile. A single multiply-accumulate unit is reused across all taps, one tap per clock. Coefficients are loaded at run time through a write port. Output uses round-half-up, arithmetic shift and saturation. The block sits between the io_in sample pins and the io_out result pins of the top-level wrapper.

## Interface
- N_TAPS, 7, number of taps (≥2)
- BW_in, 6, signed input sample width
- BW_coef, 6, signed coefficient width
- BW_out, 8, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..BW_in+BW_coef)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- x_in  input  BW_in  signed sample
- in_valid  input  1  sample offered
- in_ready  output  1  block can accept a sample
- coef_we  input  1  coefficient write strobe
- coef_addr  input  clog2(N_TAPS)  tap index
- coef_in  input  BW_coef  signed coefficient
- y_out  output  BW_out  signed filtered result, held between results
- out_valid  output  1  one-cycle strobe, y_out is new

## Operation
- Storage:
  - delay line x[0..N_TAPS-1] of BW_in bits, x[0] newest
  - coefficient file c[0..N_TAPS-1]
  - accumulator of BW_in+BW_coef+clog2(N_TAPS) bits, signed
- FSM states are IDLE, MAC and DONE. in_ready = (state==IDLE).
- IDLE:
  - in_valid high → accept the sample.
  - On accept: shift the delay line, x[0]←x_in, clear the accumulator, tap counter k←0, go to MAC.
- MAC:
  - Each cycle: acc += c[k]*x[k], then k++.
  - After k = N_TAPS-1, go to DONE.
- DONE:
  - y_out ← sat(round(acc)), out_valid=1, go to IDLE.
  - round(acc): if SHIFT>0, (acc + 2^(SHIFT-1)) >>> SHIFT; if SHIFT=0, acc unchanged.
  - sat: clamp to [-2^(BW_out-1), 2^(BW_out-1)-1].
- Coefficient writes:
  - Committed only when state==IDLE and coef_addr < N_TAPS.
  - Otherwise the write is silently ignored. This covers writes during MAC/DONE and out-of-range addresses.
- Simultaneous coef_we and accepted in_valid in IDLE: both commit on the same edge. The MAC for that sample uses the new coefficient.
- in_valid outside IDLE is ignored. No sample is queued.
- Reset (rst_n low, any cycle, including mid-MAC):
  - state=IDLE, delay line=0, all coefficients=0, accumulator=0, k=0
  - y_out=0, out_valid=0, in_ready=1 (in_ready goes high as soon as reset is asserted)
  - An interrupted computation produces no out_valid.

## Timing
- Cycle 0: edge where in_valid & in_ready is sampled high.
- Cycles 1..N_TAPS: MAC, in_ready=0.
- Cycle N_TAPS+1: DONE; out_valid=1 and y_out updated (registered outputs), in_ready=0.
- Cycle N_TAPS+2: IDLE, in_ready=1.
- Latency accept→out_valid is N_TAPS+1 cycles. Maximum throughput is one sample per N_TAPS+2 cycles.
- A coefficient write is visible to any sample accepted on the same or a later edge.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Impulse, defaults:
  - Stimulus: load c=[1,2,3,4,5,6,7]; feed 1 then six 0 samples, each sample offered as soon as in_ready.
  - Required: y_out sequence 1,2,3,4,5,6,7; an 8th zero sample gives 0; each out_valid exactly 8 cycles after its accept.
- Saturation:
  - Positive: all c=31, feed seven samples of 31 → final y_out=127 (raw 6727 clamped).
  - Negative: all c=31, feed seven samples of -32 → y_out=-128.
- Rounding, SHIFT=2 instance:
  - Stimulus: c[0]=1, other c=0.
  - Required: x=6 → y_out=2; x=-6 → y_out=-1; x=5 → y_out=1.
- Busy handling:
  - Stimulus: hold in_valid=1 with changing x_in through MAC; issue coef_we to c[0]=9 during MAC; issue coef_we with coef_addr=7.
  - Required: only the IDLE-cycle samples are accepted; c[0] is unchanged; the out-of-range write has no effect; in_ready is low from cycle 1 through cycle N_TAPS+1.
- Simultaneous write+accept:
  - Stimulus: in IDLE, c[0]←3 together with x=2, all other c=0.
  - Required: y_out=6.
- Reset mid-MAC:
  - Stimulus: pull rst_n low at cycle 3 after an accept, with nonzero coefficients loaded.
  - Required: out_valid never pulses; y_out=0 and in_ready=1 immediately; coefficients read back as 0 (impulse afterwards yields 0).
